// File: rtl/regbank_rr_arbiter.sv
// Purpose : bank of NREG WIDTH-bit registers written by NREQ requesters through a round-robin arbiter.
// Latency : winning write lands on the edge ending its request cycle; gnt pulses and rd_data shows it the cycle after.
// Backpressure: a requester holds req/req_addr/req_data until its one-cycle gnt pulse; losers simply wait.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   req[NREQ]            write request per requester
//   req_addr[NREQ*AW]    target register per requester, requester i at [i*AW +: AW]
//   req_data[NREQ*WIDTH] write data per requester, requester i at [i*WIDTH +: WIDTH]
//   gnt[NREQ]            registered one-hot write acknowledge
//   gnt_id               index of the most recently granted requester
//   rd_addr, rd_data     combinational read port (no write bypass)
//   wr_count             saturating count of committed writes
module regbank_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int NREG  = 4,
  parameter int AW    = 2,
  parameter int CW    = 16,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*AW-1:0]      req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  output logic [IDW-1:0]          gnt_id,
  input  logic [AW-1:0]           rd_addr,
  output logic [WIDTH-1:0]        rd_data,
  output logic [CW-1:0]           wr_count
);

  localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

  logic [WIDTH-1:0] bank [NREG];
  logic [IDW-1:0]   ptr;          // last granted requester; search starts just after it
  logic [NREQ-1:0]  eligible;
  logic             found;
  logic [IDW-1:0]   sel;
  logic [NREQ-1:0]  sel_onehot;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  // A requester whose grant is showing this cycle has already been written;
  // masking it stops a still-held req from committing the same data twice.
  assign eligible = req & ~gnt;

  // Round-robin search: walk ptr+1, ptr+2, ... wrapping at NREQ-1 and take
  // the first eligible requester. The explicit wrap keeps non-power-of-two
  // NREQ correct without a modulo.
  always_comb begin : pick
    logic [IDW-1:0] cand;
    found = 1'b0;
    sel   = '0;
    cand  = ptr;
    for (int off = 0; off < NREQ; off++) begin
      cand = (cand == LAST) ? '0 : cand + 1'b1;
      if (!found && eligible[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Route the winner's address and data to the bank write port.
  always_comb begin
    wr_addr    = '0;
    wr_data    = '0;
    sel_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == IDW'(i)) begin
        wr_addr       = req_addr[i*AW +: AW];
        wr_data       = req_data[i*WIDTH +: WIDTH];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Arbitration state, grant pulse and write counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt      <= '0;
      gnt_id   <= '0;
      ptr      <= LAST;          // requester 0 gets first priority
      wr_count <= '0;
    end else begin
      gnt <= found ? sel_onehot : '0;
      if (found) begin
        gnt_id <= sel;
        ptr    <= sel;
        if (wr_count != '1) begin
          wr_count <= wr_count + 1'b1;
        end
      end
    end
  end

  // Register bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        bank[r] <= '0;
      end
    end else if (found) begin
      bank[wr_addr] <= wr_data;
    end
  end

  // Plain array read: during a write cycle this still returns the old value.
  assign rd_data = bank[rd_addr];

endmodule

// File: tb/tb_regbank_rr_arbiter.sv
module tb_regbank_rr_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req;
  logic [7:0]   req_addr;
  logic [127:0] req_data;
  logic [3:0]   gnt;
  logic [1:0]   gnt_id;
  logic [1:0]   rd_addr;
  logic [31:0]  rd_data;
  logic [15:0]  wr_count;

  logic [3:0]   gnt_s;
  logic [1:0]   gnt_id_s;
  logic [31:0]  rd_data_s;
  logic [2:0]   wr_count_s;

  int checks;
  int errors;

  // Reference state: bank contents, last winner, counter.
  logic [31:0] mbank [4];
  int          mptr;
  int          mlast;   // requester whose gnt is high this cycle, -1 if none
  int          mid;
  int          mcnt;

  regbank_rr_arbiter u_dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .gnt_id(gnt_id), .rd_addr(rd_addr), .rd_data(rd_data), .wr_count(wr_count)
  );

  regbank_rr_arbiter #(.CW(3)) u_sat (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt_s), .gnt_id(gnt_id_s), .rd_addr(rd_addr), .rd_data(rd_data_s), .wr_count(wr_count_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    int w;
    int idx;
    if (reset) begin
      for (int r = 0; r < 4; r++) mbank[r] = '0;
      mptr = 3; mlast = -1; mid = 0; mcnt = 0;
    end else begin
      w = -1;
      for (int off = 1; off <= 4; off++) begin
        idx = (mptr + off) % 4;
        if (w < 0 && req[idx] && idx != mlast) w = idx;
      end
      if (w >= 0) begin
        mbank[req_addr[w*2 +: 2]] = req_data[w*32 +: 32];
        mlast = w; mptr = w; mid = w;
        if (mcnt < 65535) mcnt++;
      end else begin
        mlast = -1;
      end
    end
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic cycle();
    logic [3:0] exp_g;
    #1;
    chk("rd_pre_edge", 64'(rd_data), 64'(mbank[rd_addr]));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    exp_g = '0;
    if (mlast >= 0) exp_g[mlast] = 1'b1;
    chk("gnt", 64'(gnt), 64'(exp_g));
    chk("gnt_onehot0", 64'($onehot0(gnt)), 64'(1));
    chk("gnt_id", 64'(gnt_id), 64'(mid));
    chk("wr_count", 64'(wr_count), 64'(mcnt));
    chk("wr_count_sat", 64'(wr_count_s), 64'((mcnt > 7) ? 7 : mcnt));
    chk("rd_post_edge", 64'(rd_data), 64'(mbank[rd_addr]));
  endtask

  task automatic set_req(input int i, input logic [1:0] a, input logic [31:0] d);
    req_addr[i*2 +: 2]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    cycle();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    logic [1:0]  a0;
    logic [31:0] d0;
    logic [1:0]  rd;
    logic [3:0]  e_gnt;
    logic [1:0]  e_id;
    logic [15:0] e_cnt;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [3:0] prevg;
    checks = 0;
    errors = 0;

    tbl[0]  = '{1'b1, 4'b0000, 2'd0, 32'h0,        2'd0, 4'b0000, 2'd0, 16'd0, 32'h0};
    tbl[1]  = '{1'b0, 4'b0001, 2'd2, 32'hA213D22F, 2'd2, 4'b0001, 2'd0, 16'd1, 32'hA213D22F};
    tbl[2]  = '{1'b0, 4'b0000, 2'd2, 32'hA213D22F, 2'd2, 4'b0000, 2'd0, 16'd1, 32'hA213D22F};
    tbl[3]  = '{1'b0, 4'b0000, 2'd2, 32'hA213D22F, 2'd0, 4'b0000, 2'd0, 16'd1, 32'h0};
    tbl[4]  = '{1'b0, 4'b0000, 2'd2, 32'hA213D22F, 2'd1, 4'b0000, 2'd0, 16'd1, 32'h0};
    tbl[5]  = '{1'b0, 4'b0000, 2'd2, 32'hA213D22F, 2'd3, 4'b0000, 2'd0, 16'd1, 32'h0};
    tbl[6]  = '{1'b1, 4'b0000, 2'd0, 32'h3324DFA1, 2'd2, 4'b0000, 2'd0, 16'd0, 32'h0};
    tbl[7]  = '{1'b0, 4'b1111, 2'd0, 32'h3324DFA1, 2'd0, 4'b0001, 2'd0, 16'd1, 32'h3324DFA1};
    tbl[8]  = '{1'b0, 4'b1110, 2'd0, 32'h3324DFA1, 2'd1, 4'b0010, 2'd1, 16'd2, 32'h3324DFA2};
    tbl[9]  = '{1'b0, 4'b1100, 2'd0, 32'h3324DFA1, 2'd2, 4'b0100, 2'd2, 16'd3, 32'h3324DFA3};
    tbl[10] = '{1'b0, 4'b1000, 2'd0, 32'h3324DFA1, 2'd3, 4'b1000, 2'd3, 16'd4, 32'h3324DFA4};
    tbl[11] = '{1'b0, 4'b0000, 2'd0, 32'h3324DFA1, 2'd0, 4'b0000, 2'd3, 16'd4, 32'h3324DFA1};

    reset = 1'b1; req = '0; req_addr = '0; req_data = '0; rd_addr = '0;
    for (int r = 0; r < 4; r++) mbank[r] = '0;
    mptr = 3; mlast = -1; mid = 0; mcnt = 0;
    @(posedge clk);
    @(negedge clk);

    // Single write, then four requesters granted in order.
    for (int i = 1; i < 4; i++) set_req(i, 2'(i), 32'h3324DFA1 + 32'(i));
    for (int v = 0; v < 12; v++) begin
      reset   = tbl[v].rst;
      req     = tbl[v].rq;
      rd_addr = tbl[v].rd;
      set_req(0, tbl[v].a0, tbl[v].d0);
      cycle();
      chk($sformatf("tbl%0d_gnt", v), 64'(gnt), 64'(tbl[v].e_gnt));
      chk($sformatf("tbl%0d_id", v), 64'(gnt_id), 64'(tbl[v].e_id));
      chk($sformatf("tbl%0d_cnt", v), 64'(wr_count), 64'(tbl[v].e_cnt));
      chk($sformatf("tbl%0d_rd", v), 64'(rd_data), 64'(tbl[v].e_rd));
    end
    reset = 1'b0;

    // Fairness: 1 and 3 held for 8 cycles.
    do_reset();
    set_req(1, 2'd1, 32'h11111111);
    set_req(3, 2'd3, 32'h33333333);
    req = 4'b1010;
    prevg = '0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("t3_gnt", 64'(gnt), 64'((k % 2 == 0) ? 4'b0010 : 4'b1000));
      chk("t3_no_repeat", 64'(gnt != prevg), 64'(1));
      chk("t3_cnt", 64'(wr_count), 64'(k + 1));
      prevg = gnt;
    end
    req = '0;
    cycle();
    chk("t3_cnt_final", 64'(wr_count), 64'(8));
    chk("t3_id_final", 64'(gnt_id), 64'(3));

    // Collision on addr 1 with read of addr 1 held.
    do_reset();
    rd_addr = 2'd1;
    set_req(0, 2'd1, 32'h12353ABC);
    set_req(2, 2'd1, 32'h0000FFFF);
    req = 4'b0101;
    #1 chk("t4_old_first", 64'(rd_data), 64'(0));
    cycle();
    chk("t4_gnt0", 64'(gnt), 64'(4'b0001));
    chk("t4_rd_first", 64'(rd_data), 64'(32'h12353ABC));
    req = 4'b0100;
    #1 chk("t4_old_second", 64'(rd_data), 64'(32'h12353ABC));
    cycle();
    chk("t4_gnt2", 64'(gnt), 64'(4'b0100));
    chk("t4_rd_second", 64'(rd_data), 64'(32'h0000FFFF));
    req = '0;
    cycle();
    chk("t4_rd_hold", 64'(rd_data), 64'(32'h0000FFFF));

    // Reset while requester 2 is eligible.
    set_req(2, 2'd3, 32'hDEADBEEF);
    req   = 4'b0100;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t5_gnt_zero", 64'(gnt), 64'(0));
    chk("t5_cnt_zero", 64'(wr_count), 64'(0));
    req = '0;
    for (int r = 0; r < 4; r++) begin
      rd_addr = 2'(r);
      cycle();
      chk("t5_bank_zero", 64'(rd_data), 64'(0));
    end
    set_req(0, 2'd0, 32'hCAFE0000);
    req = 4'b0101;
    cycle();
    chk("t5_first_after_reset", 64'(gnt), 64'(4'b0001));
    req = '0;
    cycle();

    // Saturation of the CW=3 instance.
    do_reset();
    set_req(0, 2'd0, 32'hAAAA0000);
    set_req(1, 2'd1, 32'hBBBB0000);
    req = 4'b0011;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      chk("t6_sat_cnt", 64'(wr_count_s), 64'((k < 7) ? k : 7));
      chk("t6_full_cnt", 64'(wr_count), 64'(k));
    end
    req = '0;
    cycle();

    // Random traffic obeying the handshake.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          if (mlast == i) begin
            if ($urandom_range(1) == 0) req[i] = 1'b0;
            else set_req(i, 2'($urandom_range(3)), $urandom);
          end else if ($urandom_range(19) == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(2) == 0) begin
          req[i] = 1'b1;
          set_req(i, 2'($urandom_range(3)), $urandom);
        end
      end
      rd_addr = 2'($urandom_range(3));
      reset   = ($urandom_range(39) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
